// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer: FSM encodings and the
// counter width helper used by the debouncer and its tick generator.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  // Width of a counter that must hold 0..range_n-1 (at least one bit).
  function automatic int cnt_width(input int range_n);
    return (range_n < 2) ? 1 : $clog2(range_n);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running clock-enable generator: tick is high for one clk cycle out of
// every DIV, on the cycle where the counter sits at DIV-1.
module tick_gen
  import debounce_pkg::*;
#(
  parameter int DIV = 12000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = cnt_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchroniser, tick-sampled debounce FSM,
// registered stable level, one-cycle press/release pulses and a press counter.
module button_debounce
  import debounce_pkg::*;
#(
  parameter int TICK_DIV     = 12000,
  parameter int STABLE_TICKS = 20,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_release,
  output logic [7:0] press_count,
  output logic [1:0] state
);

  localparam int CW = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  logic          s1;
  logic          s2;
  logic          btn_s;
  logic          tick;
  state_t        fsm;
  logic [CW-1:0] cnt;

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  // Polarity fix-up after the synchroniser so the FSM always sees 1 = pressed.
  assign btn_s = s2 ^ ACTIVE_LOW;
  assign state = fsm;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm         <= IDLE_LOW;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      press_count <= 8'd0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      if (tick) begin
        case (fsm)
          IDLE_LOW: begin
            if (btn_s) begin
              fsm <= WAIT_HIGH;
              cnt <= CW'(1);
            end
          end
          WAIT_HIGH: begin
            if (!btn_s) begin
              fsm <= IDLE_LOW;
              cnt <= '0;
            end else if (cnt == LAST) begin
              fsm         <= IDLE_HIGH;
              cnt         <= '0;
              btn_level   <= 1'b1;
              btn_press   <= 1'b1;
              press_count <= press_count + 8'd1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          IDLE_HIGH: begin
            if (!btn_s) begin
              fsm <= WAIT_LOW;
              cnt <= CW'(1);
            end
          end
          WAIT_LOW: begin
            if (btn_s) begin
              fsm <= IDLE_HIGH;
              cnt <= '0;
            end else if (cnt == LAST) begin
              fsm         <= IDLE_LOW;
              cnt         <= '0;
              btn_level   <= 1'b0;
              btn_release <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            fsm <= IDLE_LOW;
            cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule
